alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU consuming the 4-bit operation code produced by ALU control.
//  Single-cycle ops (LUI/AND/OR/ADD/SUB) return a registered result after 1 cycle.
//  MULTU runs an iterative shift-add multiply over DATA_WIDTH cycles.
//  A valid/ready handshake stalls the pipeline front end while a multiply is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand/result word width; must be even and >= 4
// PORTS
//  clk                input   1           rising-edge clock
//  reset              input   1           asynchronous, active-low reset
//  valid_i            input   1           operands and op are valid this cycle
//  ready_o            output  1           unit can accept; accept = valid_i & ready_o
//  alu_operation_i    input   4           op code: 0000 LUI, 0001 AND, 0010 OR, 0011 ADD, 0100 SUB, 0101 MULTU
//  a_i                input   DATA_WIDTH  operand A (rs)
//  b_i                input   DATA_WIDTH  operand B (rt/immediate)
//  valid_o            output  1           one-cycle pulse: result_o/result_hi_o/zero_o are new
//  result_o           output  DATA_WIDTH  result (low word for MULTU)
//  result_hi_o        output  DATA_WIDTH  MULTU high word; 0 after every non-MULTU op
//  zero_o             output  1           result_o == 0, registered with result_o
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; ready_o=1, valid_o=0, result_o=0, result_hi_o=0,
//   zero_o=0; multiply counter and accumulators cleared. Asserting reset mid-multiply aborts it; no valid_o.
//  FSM states: IDLE, MUL.
//  IDLE, accept of non-MULTU op at edge E: after E, result_o/zero_o updated, result_hi_o=0,
//   valid_o=1 for one cycle; state stays IDLE, ready_o stays 1 (1 op/cycle back-to-back).
//  Op semantics (modulo 2^DATA_WIDTH, no overflow detection/trap):
//   LUI: b_i << (DATA_WIDTH/2); AND: a&b; OR: a|b; ADD: a+b; SUB: a-b.
//   Any other code (incl. 1001): result_o=0, zero_o=1, valid_o still pulses.
//  IDLE, accept of MULTU at edge E0: latch a_i, b_i; ready_o=0 after E0; state -> MUL.
//   MUL: one multiplier bit (LSB first) per cycle into a 2*DATA_WIDTH accumulator;
//   counter runs 0..DATA_WIDTH-1. At edge E0+DATA_WIDTH: result_hi_o/result_o = product
//   high/low (unsigned), zero_o = (low word==0), valid_o=1 one cycle, ready_o=1, state -> IDLE.
//   Latency: DATA_WIDTH cycles accept-to-valid_o; next op accepted at E0+DATA_WIDTH+1 or later.
//  valid_i while ready_o=0: ignored, no state change; upstream must hold its op.
//  valid_o=0 cycles: result_o, result_hi_o, zero_o hold last values.
//  Inputs sampled only on the accept edge; changes afterwards do not affect an op in progress.
// TESTING
//  1) ADD a=5, b=7 accepted -> next cycle valid_o=1, result_o=12, zero_o=0, result_hi_o=0.
//  2) SUB a=7,b=7 then ADD a=0xFFFFFFFF,b=1 back-to-back -> 0/zero_o=1, then 0/zero_o=1; ready_o stays 1.
//  3) LUI b=0x00001234 -> result_o=0x12340000; op 1001 -> result_o=0, zero_o=1, valid_o pulses.
//  4) MULTU a=0xFFFFFFFF, b=2 -> ready_o low 32 cycles; valid_i+ADD during stall ignored;
//     valid_o at cycle 32 with result_hi_o=1, result_o=0xFFFFFFFE; ready_o high the same cycle.
//  5) MULTU a=0x10000, b=0x10000 -> result_hi_o=1, result_o=0, zero_o=1.
//  6) reset low at cycle 10 of MULTU -> all outputs reset values immediately, no valid_o; ADD 1+1 after release -> 2.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: LUI/AND/OR/ADD/SUB in one cycle, MULTU via iterative shift-add.
// Latency: 1 cycle for single-cycle ops, DATA_WIDTH cycles accept-to-valid_o for MULTU.
// Backpressure: ready_o drops while a multiply is in flight; valid_i is ignored until it returns.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] result_hi_o,
    output logic                  zero_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [3:0] OP_LUI   = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [DATA_WIDTH-1:0]   result_hi_q, result_hi_d;
    logic                    zero_q, zero_d;
    logic                    valid_q, valid_d;

    logic                    accept;
    logic                    is_mul;
    logic                    mul_last;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic [2*DATA_WIDTH-1:0] acc_sum;

    assign accept   = valid_i & ready_o;
    assign is_mul   = (alu_operation_i == OP_MULTU);
    assign mul_last = (cnt_q == CW'(DATA_WIDTH - 1));

    // State register; reset aborts any multiply in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter MUL on an accepted MULTU, leave after the last multiplier bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last)         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output: the unit only accepts work while idle.
    always_comb begin
        ready_o = (state_q == S_IDLE);
    end

    // Single-cycle op result; unknown codes produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_operation_i)
            OP_LUI:  alu_res = b_i << (DATA_WIDTH / 2);
            OP_AND:  alu_res = a_i & b_i;
            OP_OR:   alu_res = a_i | b_i;
            OP_ADD:  alu_res = a_i + b_i;
            OP_SUB:  alu_res = a_i - b_i;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Datapath next state: operand latch, multiply iteration and registered outputs.
    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        valid_d     = 1'b0;
        if (state_q == S_IDLE) begin
            if (accept) begin
                if (is_mul) begin
                    mcand_d  = {{DATA_WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    result_d    = alu_res;
                    result_hi_d = '0;
                    zero_d      = (alu_res == '0);
                    valid_d     = 1'b1;
                end
            end
        end else begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
                cnt_d       = '0;
                result_d    = acc_sum[DATA_WIDTH-1:0];
                result_hi_d = acc_sum[2*DATA_WIDTH-1:DATA_WIDTH];
                zero_d      = (acc_sum[DATA_WIDTH-1:0] == '0);
                valid_d     = 1'b1;
            end
        end
    end

    // Datapath registers; outputs hold their values between valid_o pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            valid_q     <= valid_d;
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zero_o      = zero_q;

endmodule
